load_store_sequencer: RTL and testbench
=======================================

// Module: load_store_sequencer
// PURPOSE
//  Sits between the datapath's MEM stage and the byte-wide data memory. Splits byte/half/word
//  loads and stores into sequential single-byte memory accesses, big-endian (lowest address = MSB).
//  Assembles and sign/zero-extends load data. Holds busy high so the pipeline stalls meanwhile.
// PARAMETERS
//  ADDR_W  12  significant byte-address bits (4096-byte memory); upper addr bits driven as zero
// PORTS
//  CLK           in   1   clock; all state updates on posedge
//  RST_N         in   1   reset, synchronous, active-low
//  req           in   1   access request; sampled only while idle
//  we            in   1   1 = store, 0 = load (latched with req)
//  size          in   2   00 byte, 01 half, 10 word, 11 illegal
//  sign_ext      in   1   load extension: 1 = sign-extend, 0 = zero-extend
//  addr          in   32  byte address of the access
//  wdata         in   32  store data; byte/half taken from the low bits
//  busy          out  1   high from the accept edge until the DONE state is left
//  done          out  1   one-cycle completion pulse
//  err           out  1   one-cycle pulse with done on misaligned or illegal access
//  rdata         out  32  load result; valid from done, held until next load completes
//  mem_write     out  1   byte write strobe to data memory (memory writes on negedge)
//  mem_addr      out  32  byte address to data memory
//  mem_data_in   out  32  {24'b0, byte} to data memory
//  mem_word_out  in   8   combinational byte read from data memory at mem_addr
// BEHAVIOUR
//  Reset (RST_N low at posedge): state IDLE; busy, done, err, mem_write = 0; rdata = 0;
//   mem_addr = 0; mem_data_in = 0; internal counter = 0.
//  States: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: on posedge with req=1 latch we, size, sign_ext, addr[ADDR_W-1:0], wdata; cnt = 0.
//   If size=11, or half with addr[0]=1, or word with addr[1:0]!=0: go DONE with err flag
//   set, no memory access. Otherwise go ACCESS. req=0: stay IDLE.
//  ACCESS: nbytes = 1/2/4 for byte/half/word. mem_addr = base + cnt (zero-extended),
//   mem_write = latched we. Store byte order: word sends wdata[31:24],[23:16],[15:8],[7:0];
//   half sends wdata[15:8],[7:0]; byte sends wdata[7:0]. Loads: at each posedge shift
//   mem_word_out into an assembly register (first byte = most significant).
//   Every posedge cnt++; when cnt = nbytes-1, go DONE.
//  DONE: done = 1 for exactly one cycle; err = 1 if rejected. For successful loads, rdata =
//   assembled value sign/zero-extended from bit 7 (byte) or bit 15 (half); word unchanged.
//   Stores and errors leave rdata unchanged. Next posedge -> IDLE; req is accepted again from
//   the following IDLE cycle, so there is no back-to-back accept in DONE.
//  Outside ACCESS: mem_write = 0; mem_addr and mem_data_in hold their last value.
//  Timing: accept edge T0; ACCESS cycles T0+1..T0+nbytes; done high during cycle T0+nbytes+1.
//   Byte = 2 cycles to done, half = 3, word = 5; error = done in the cycle after accept.
//  mem signals change only after posedge, so they are stable at the memory's negedge write.
//  req, addr and wdata changes while busy are ignored; captured values are used throughout.
//  Aligned accesses never cross the ADDR_W boundary; address bits above ADDR_W are dropped.
//  Reset mid-operation: abort at the reset edge; no done pulse. Bytes already written stay.
//   The negedge inside the cycle where RST_N first goes low still writes if mem_write was high.
// TESTING
//  1. Word store 0xDEADBEEF @0x010 -> mem[0x10..0x13] = DE,AD,BE,EF; 4 mem_write cycles;
//     done in 5th cycle after accept; err=0.
//  2. mem[0x20]=0x80: byte load sign_ext=1 -> rdata 0xFFFFFF80; sign_ext=0 -> 0x00000080.
//  3. Half load @0x030 holding 0x9A,0x12: sign_ext=1 -> 0xFFFF9A12; word load of
//     mem[0..3]=03,04,03,01 -> 0x03040301.
//  4. Half store @0x011 and size=11 -> err+done the cycle after accept, mem_write never 1.
//  5. Pulse req with new addr while busy -> ignored; only the original access completes.
//  6. RST_N low after 2 bytes of a word store -> IDLE, no done, bytes 3-4 unchanged, busy=0.

Source files
------------

// File: rtl/load_store_sequencer_if.sv
// ---------------------------------------------------------------------------
// load_store_sequencer_if
//   Bundles the pipeline-side request/response handshake and the byte-wide
//   data-memory bus of the load/store sequencer.
//
//   Pipeline side : req, we, size, sign_ext, addr, wdata  -> sequencer
//                   busy, done, err, rdata                <- sequencer
//   Memory side   : mem_write, mem_addr, mem_data_in      <- sequencer
//                   mem_word_out (combinational read)     -> sequencer
//
//   master : the pipeline plus data memory (drives requests and read data)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface load_store_sequencer_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [7:0]  mem_word_out;

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_word_out,
        input  busy, done, err, rdata, mem_write, mem_addr, mem_data_in
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_word_out,
        output busy, done, err, rdata, mem_write, mem_addr, mem_data_in
    );
endinterface

// File: rtl/load_store_sequencer.sv
// ---------------------------------------------------------------------------
// load_store_sequencer
//   Sits between the MEM stage and a byte-wide data memory. Each byte, half
//   or word access is split into sequential single-byte memory accesses in
//   big-endian order (lowest address carries the most significant byte).
//   Load bytes are assembled and sign/zero-extended; busy stalls the pipeline
//   for the whole transfer.
//
//   Ports
//     CLK    : clock, all state changes on posedge
//     RST_N  : synchronous active-low reset
//     bus    : load_store_sequencer_if.slave (request, response, memory bus)
//
//   Timing: accept edge T0, ACCESS cycles T0+1..T0+nbytes, done high in cycle
//   T0+nbytes+1. Rejected accesses pulse done/err in the cycle after accept.
//   All memory-side outputs are registered so they are stable at the
//   memory's negedge write.
// ---------------------------------------------------------------------------
module load_store_sequencer #(
    parameter int ADDR_W = 12
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    load_store_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Index of the final byte of an access (nbytes - 1).
    function automatic logic [1:0] last_idx(input logic [1:0] sz);
        case (sz)
            SZ_HALF: last_idx = 2'd1;
            SZ_WORD: last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    endfunction

    // Store byte for sequence position idx: position 0 carries the most
    // significant byte of the operand, so the lane counts down from the top.
    function automatic logic [7:0] lane_byte(input logic [31:0] wd,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  idx);
        logic [1:0] lane;
        lane      = last_idx(sz) - idx;
        lane_byte = 8'(wd >> {lane, 3'b000});
    endfunction

    function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: is_bad = 1'b0;
            SZ_HALF: is_bad = a[0];
            SZ_WORD: is_bad = (a != 2'b00);
            default: is_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v,
                                           input logic [1:0]  sz,
                                           input logic        sx);
        case (sz)
            SZ_BYTE: extend = {{24{sx & v[7]}},  v[7:0]};
            SZ_HALF: extend = {{16{sx & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    state_t              state_q,       state_d;
    logic [1:0]          cnt_q,         cnt_d;
    logic                we_q,          we_d;
    logic [1:0]          size_q,        size_d;
    logic                sign_ext_q,    sign_ext_d;
    logic [ADDR_W-1:0]   base_q,        base_d;
    logic [31:0]         wdata_q,       wdata_d;
    logic [23:0]         asm_q,         asm_d;
    logic                busy_q,        busy_d;
    logic                done_q,        done_d;
    logic                err_q,         err_d;
    logic [31:0]         rdata_q,       rdata_d;
    logic                mem_write_q,   mem_write_d;
    logic [31:0]         mem_addr_q,    mem_addr_d;
    logic [31:0]         mem_data_in_q, mem_data_in_d;

    logic [31:0]         asm_next;

    // Address bits above ADDR_W are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:ADDR_W];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        size_d        = size_q;
        sign_ext_d    = sign_ext_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        asm_d         = asm_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        rdata_d       = rdata_q;
        mem_write_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        asm_next      = {asm_q, bus.mem_word_out};

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d       = bus.we;
                    size_d     = bus.size;
                    sign_ext_d = bus.sign_ext;
                    base_d     = bus.addr[ADDR_W-1:0];
                    wdata_d    = bus.wdata;
                    cnt_d      = 2'd0;
                    asm_d      = 24'd0;
                    busy_d     = 1'b1;
                    if (is_bad(bus.size, bus.addr[1:0])) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        // First byte is presented straight from the request so
                        // the memory sees it in the first ACCESS cycle.
                        state_d       = S_ACCESS;
                        mem_write_d   = bus.we;
                        mem_addr_d    = 32'(bus.addr[ADDR_W-1:0]);
                        mem_data_in_d = {24'd0, lane_byte(bus.wdata, bus.size, 2'd0)};
                    end
                end
            end

            S_ACCESS: begin
                asm_d = asm_next[23:0];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_idx(size_q)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = extend(asm_next, size_q, sign_ext_q);
                    end
                end else begin
                    // Set up the following byte; memory address and data hold
                    // their last value once the access ends.
                    mem_write_d   = we_q;
                    mem_addr_d    = 32'(base_q + ADDR_W'(cnt_d));
                    mem_data_in_d = {24'd0, lane_byte(wdata_q, size_q, cnt_d)};
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, matching real hardware.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            cnt_q         <= 2'd0;
            we_q          <= 1'b0;
            size_q        <= 2'd0;
            sign_ext_q    <= 1'b0;
            base_q        <= '0;
            wdata_q       <= 32'd0;
            asm_q         <= 24'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= 32'd0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_data_in_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            size_q        <= size_d;
            sign_ext_q    <= sign_ext_d;
            base_q        <= base_d;
            wdata_q       <= wdata_d;
            asm_q         <= asm_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.rdata       = rdata_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// ---------------------------------------------------------------------------
// tb_load_store_sequencer
//   Directed bench for load_store_sequencer with a 4096-byte behavioural data
//   memory (negedge write, combinational read). Expected values are written
//   out by hand for each step.
// ---------------------------------------------------------------------------
module tb_load_store_sequencer;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic CLK = 1'b0;
    logic RST_N;

    load_store_sequencer_if bus ();

    load_store_sequencer #(.ADDR_W(12)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Data memory model; preload port shares the single writing process.
    logic [7:0]  mem [0:4095] = '{default: 8'h00};
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;

    assign bus.mem_word_out = mem[bus.mem_addr[11:0]];

    always @(negedge CLK) begin
        if (bus.mem_write) mem[bus.mem_addr[11:0]] <= bus.mem_data_in[7:0];
        else if (pre_we)   mem[pre_addr]            <= pre_data;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge CLK); #1;
        pre_we   = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Issues one access from IDLE and waits (bounded) for done. cyc is the
    // cycle index, counted from the accept edge, in which done was seen.
    task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] d,
                              output int cyc, output int nwr);
        bus.we       = w;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.addr     = a;
        bus.wdata    = d;
        bus.req      = 1'b1;
        @(posedge CLK); #1;
        bus.req      = 1'b0;
        bus.addr     = 32'hFFFF_FFFF;
        bus.wdata    = 32'h0;
        cyc = 1;
        nwr = 0;
        while (!bus.done && cyc < 20) begin
            if (bus.mem_write) nwr++;
            @(posedge CLK); #1;
            cyc++;
        end
    endtask

    // Cycle after done: pulse must be over and the sequencer idle again.
    task automatic after_done(input string tag);
        @(posedge CLK); #1;
        check({tag, "_done_low"}, 32'(bus.done), 32'h0);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nwr;
        int ndone;

        RST_N        = 1'b0;
        pre_we       = 1'b0;
        pre_addr     = '0;
        pre_data     = '0;
        bus.req      = 1'b0;
        bus.we       = 1'b0;
        bus.size     = SZ_B;
        bus.sign_ext = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy",      32'(bus.busy),      32'h0);
        check("rst_done",      32'(bus.done),      32'h0);
        check("rst_err",       32'(bus.err),       32'h0);
        check("rst_memw",      32'(bus.mem_write), 32'h0);
        check("rst_rdata",     bus.rdata,          32'h0);
        check("rst_mem_addr",  bus.mem_addr,       32'h0);
        check("rst_mem_data",  bus.mem_data_in,    32'h0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Byte loads of 0x80, upper address bits dropped on the first one
        poke(12'h020, 8'h80);
        run_access(1'b0, SZ_B, 1'b1, 32'h1234_5020, 32'h0, cyc, nwr);
        check("lb_sx_cycles", 32'(cyc),        32'd2);
        check("lb_sx_memw",   32'(nwr),        32'd0);
        check("lb_sx_busy",   32'(bus.busy),   32'h1);
        check("lb_sx_err",    32'(bus.err),    32'h0);
        check("lb_sx_rdata",  bus.rdata,       32'hFFFF_FF80);
        check("lb_sx_maddr",  bus.mem_addr,    32'h0000_0020);
        after_done("lb_sx");
        run_access(1'b0, SZ_B, 1'b0, 32'h0000_0020, 32'h0, cyc, nwr);
        check("lb_zx_rdata",  bus.rdata,       32'h0000_0080);
        after_done("lb_zx");

        // Half and word loads
        poke(12'h030, 8'h9A);
        poke(12'h031, 8'h12);
        poke(12'h000, 8'h03);
        poke(12'h001, 8'h04);
        poke(12'h002, 8'h03);
        poke(12'h003, 8'h01);
        run_access(1'b0, SZ_H, 1'b1, 32'h0000_0030, 32'h0, cyc, nwr);
        check("lh_sx_cycles", 32'(cyc),  32'd3);
        check("lh_sx_rdata",  bus.rdata, 32'hFFFF_9A12);
        after_done("lh_sx");
        run_access(1'b0, SZ_H, 1'b0, 32'h0000_0030, 32'h0, cyc, nwr);
        check("lh_zx_rdata",  bus.rdata, 32'h0000_9A12);
        after_done("lh_zx");
        run_access(1'b0, SZ_W, 1'b1, 32'h0000_0000, 32'h0, cyc, nwr);
        check("lw_cycles",    32'(cyc),  32'd5);
        check("lw_rdata",     bus.rdata, 32'h0304_0301);
        after_done("lw");

        // Word, half and byte stores; rdata must keep the last load result
        run_access(1'b1, SZ_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, cyc, nwr);
        check("sw_cycles",    32'(cyc),         32'd5);
        check("sw_memw",      32'(nwr),         32'd4);
        check("sw_err",       32'(bus.err),     32'h0);
        check("sw_rdata",     bus.rdata,        32'h0304_0301);
        check("sw_maddr",     bus.mem_addr,     32'h0000_0013);
        check("sw_mdata",     bus.mem_data_in,  32'h0000_00EF);
        check("sw_m10",       32'(mem[12'h010]), 32'hDE);
        check("sw_m11",       32'(mem[12'h011]), 32'hAD);
        check("sw_m12",       32'(mem[12'h012]), 32'hBE);
        check("sw_m13",       32'(mem[12'h013]), 32'hEF);
        after_done("sw");
        run_access(1'b1, SZ_H, 1'b0, 32'h0000_00F2, 32'h7777_ABCD, cyc, nwr);
        check("sh_cycles",    32'(cyc),          32'd3);
        check("sh_memw",      32'(nwr),          32'd2);
        check("sh_mF2",       32'(mem[12'h0F2]), 32'hAB);
        check("sh_mF3",       32'(mem[12'h0F3]), 32'hCD);
        after_done("sh");
        run_access(1'b1, SZ_B, 1'b0, 32'h0000_00F5, 32'h1234_565A, cyc, nwr);
        check("sb_cycles",    32'(cyc),          32'd2);
        check("sb_memw",      32'(nwr),          32'd1);
        check("sb_mF5",       32'(mem[12'h0F5]), 32'h5A);
        check("sb_mF4",       32'(mem[12'h0F4]), 32'h00);
        after_done("sb");

        // Rejected accesses: done+err the cycle after accept, no memory write
        run_access(1'b1, SZ_H, 1'b0, 32'h0000_0011, 32'h0000_FFFF, cyc, nwr);
        check("mis_h_cycles", 32'(cyc),           32'd1);
        check("mis_h_err",    32'(bus.err),       32'h1);
        check("mis_h_memw",   32'(bus.mem_write), 32'h0);
        check("mis_h_m11",    32'(mem[12'h011]),  32'hAD);
        check("mis_h_rdata",  bus.rdata,          32'h0304_0301);
        after_done("mis_h");
        check("mis_h_err_low", 32'(bus.err),      32'h0);
        run_access(1'b0, SZ_X, 1'b0, 32'h0000_0040, 32'h0, cyc, nwr);
        check("ill_cycles",   32'(cyc),           32'd1);
        check("ill_err",      32'(bus.err),       32'h1);
        check("ill_memw",     32'(bus.mem_write), 32'h0);
        check("ill_rdata",    bus.rdata,          32'h0304_0301);
        after_done("ill");
        run_access(1'b1, SZ_W, 1'b0, 32'h0000_0012, 32'h0, cyc, nwr);
        check("mis_w_err",    32'(bus.err),       32'h1);
        check("mis_w_m12",    32'(mem[12'h012]),  32'hBE);
        after_done("mis_w");

        // New request while busy is ignored; req held in DONE is not accepted
        bus.we       = 1'b1;
        bus.size     = SZ_W;
        bus.sign_ext = 1'b0;
        bus.addr     = 32'h0000_0100;
        bus.wdata    = 32'h1122_3344;
        bus.req      = 1'b1;
        @(posedge CLK); #1;
        bus.addr     = 32'h0000_0200;
        bus.wdata    = 32'hAAAA_AAAA;
        bus.size     = SZ_B;
        @(posedge CLK); #1;
        bus.req      = 1'b0;
        cyc = 2;
        while (!bus.done && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("busy_req_cycles", 32'(cyc),          32'd5);
        check("busy_req_m100",   32'(mem[12'h100]), 32'h11);
        check("busy_req_m101",   32'(mem[12'h101]), 32'h22);
        check("busy_req_m102",   32'(mem[12'h102]), 32'h33);
        check("busy_req_m103",   32'(mem[12'h103]), 32'h44);
        check("busy_req_m200",   32'(mem[12'h200]), 32'h00);
        bus.addr  = 32'h0000_0300;
        bus.wdata = 32'h0000_0055;
        bus.req   = 1'b1;
        @(posedge CLK); #1;
        check("done_req_busy",   32'(bus.busy),     32'h0);
        bus.req   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("done_req_busy2",  32'(bus.busy),     32'h0);
        check("done_req_m300",   32'(mem[12'h300]), 32'h00);

        // Reset after two bytes of a word store
        bus.we       = 1'b1;
        bus.size     = SZ_W;
        bus.addr     = 32'h0000_0050;
        bus.wdata    = 32'hCAFE_F00D;
        bus.req      = 1'b1;
        @(posedge CLK); #1;
        bus.req      = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        check("rst_mid_busy",   32'(bus.busy),      32'h0);
        check("rst_mid_done",   32'(bus.done),      32'h0);
        check("rst_mid_memw",   32'(bus.mem_write), 32'h0);
        check("rst_mid_maddr",  bus.mem_addr,       32'h0);
        check("rst_mid_rdata",  bus.rdata,          32'h0);
        RST_N = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            if (bus.done) ndone++;
        end
        check("rst_mid_no_done", 32'(ndone),        32'd0);
        check("rst_mid_m50",    32'(mem[12'h050]),  32'hCA);
        check("rst_mid_m51",    32'(mem[12'h051]),  32'hFE);
        check("rst_mid_m52",    32'(mem[12'h052]),  32'h00);
        check("rst_mid_m53",    32'(mem[12'h053]),  32'h00);

        // Recovery after reset
        run_access(1'b0, SZ_B, 1'b1, 32'h0000_0050, 32'h0, cyc, nwr);
        check("recover_cycles", 32'(cyc),  32'd2);
        check("recover_rdata",  bus.rdata, 32'hFFFF_FFCA);
        after_done("recover");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
